// File: rtl/sramlike_port_bridge.sv
// -----------------------------------------------------------------------------
// sramlike_port_bridge
//
// Purpose:
//   Bridges the pipeline's SRAM-style port (en/wen/addr/wdata with a stall
//   back-pressure) to an SRAM-like request/addr_ok/data_ok transaction toward
//   the cache. One instance per port (instruction and data).
//
//   Each access runs through a small FSM:
//     IDLE  - issue req; a same-cycle addr_ok+data_ok completes immediately.
//     WAIT  - address accepted, waiting for data_ok.
//     DONE  - result registered; stays here while the global hold is high so
//             the result register is stable until the pipeline consumes it.
//     DRAIN - a flush cancelled an accepted transaction; swallow its data_ok
//             before any new request is allowed.
//
// Parameters:
//   ADDR_W  address width (default 32)
//   DATA_W  data width, 32 or 64 (default 32)
//   STRB_W  byte-strobe width, derived as DATA_W/8
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   sram_en/wen/addr/wdata       pipeline-side request (wen==0 means read)
//   sram_rdata                   read result toward the pipeline
//   stall                        stall request toward the pipeline
//   hold                         global stall; result held while high
//   flush                        cancels the current access
//   req/wr/size/addr/wdata       SRAM-like request toward the cache
//   rdata/addr_ok/data_ok        SRAM-like response from the cache
//
// Optional build macro:
//   SRAMLIKE_RDATA_BYPASS_EN  forwards rdata combinationally in the cycle
//                             data_ok is accepted and, when hold is low,
//                             drops stall in that cycle and skips DONE.
// -----------------------------------------------------------------------------
module sramlike_port_bridge #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    // pipeline side
    input  logic              sram_en,
    input  logic [STRB_W-1:0] sram_wen,
    input  logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_wdata,
    output logic [DATA_W-1:0] sram_rdata,
    output logic              stall,
    input  logic              hold,
    input  logic              flush,
    // cache side
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              addr_ok,
    input  logic              data_ok
);

    localparam int          ADDR_LSB  = $clog2(STRB_W);
    localparam logic [1:0]  SIZE_FULL = 2'(ADDR_LSB);
    localparam int          NUM_HALF  = STRB_W / 2;
    localparam int          NUM_WORD  = STRB_W / 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // ------------------------------------------------------------------
    // Write size decode: only aligned contiguous 1/2/4-byte strobe patterns
    // get a narrow size; everything else (including full width) is sent as
    // a full-width access.
    // ------------------------------------------------------------------
    logic [STRB_W-1:0]   byte_hit;
    logic [NUM_HALF-1:0] half_hit;
    logic [NUM_WORD-1:0] word_hit;

    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_byte
            assign byte_hit[gi] = (sram_wen == (STRB_W'(1) << gi));
        end
        for (genvar gi = 0; gi < NUM_HALF; gi++) begin : g_half
            assign half_hit[gi] = (sram_wen == (STRB_W'(3) << (2 * gi)));
        end
        for (genvar gi = 0; gi < NUM_WORD; gi++) begin : g_word
            assign word_hit[gi] = (sram_wen == (STRB_W'(15) << (4 * gi)));
        end
    endgenerate

    logic [1:0] wr_size;

    always_comb begin
        wr_size = SIZE_FULL;
        if (|byte_hit) begin
            wr_size = 2'd0;
        end else if (|half_hit) begin
            wr_size = 2'd1;
        end else if (|word_hit) begin
            wr_size = 2'd2;
        end
    end

    // Request payload is purely combinational from the pipeline port.
    assign wr    = |sram_wen;
    assign size  = wr ? wr_size : SIZE_FULL;
    assign addr  = wr ? sram_addr
                      : {sram_addr[ADDR_W-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
    assign wdata = sram_wdata;

    // ------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------
    logic req_c;
    logic accept;   // data_ok accepted for a live transaction this cycle

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        req_c      = 1'b0;
        stall      = 1'b0;
        accept     = 1'b0;
        sram_rdata = rdata_q;

        case (state_q)
            IDLE: begin
                req_c = sram_en & ~flush;
                stall = sram_en & ~flush;
                if (req_c && addr_ok) begin
                    // same-cycle data_ok wins over going to WAIT
                    if (data_ok) begin
                        accept = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = ~flush;
                if (flush) begin
                    // the cache still owes a response; swallow it in DRAIN
                    state_d = data_ok ? IDLE : DRAIN;
                end else if (data_ok) begin
                    accept = 1'b1;
                end
            end
            DONE: begin
                if (!hold || flush) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                stall = sram_en;
                if (data_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            rdata_d = rdata;
            state_d = DONE;
`ifdef SRAMLIKE_RDATA_BYPASS_EN
            sram_rdata = rdata;
            // with no global hold the pipeline consumes the bypassed data
            // right now, so the registered DONE cycle is not needed
            if (!hold) begin
                stall   = 1'b0;
                state_d = IDLE;
            end
`endif
        end
    end

    assign req = req_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sramlike_port_bridge.sv
// -----------------------------------------------------------------------------
// tb_sramlike_port_bridge
//
// Directed testbench for sramlike_port_bridge (default 32-bit build, bypass
// macro undefined). Inputs change 1 time unit after the rising edge; outputs
// are sampled 4 units later, well away from the edge.
// -----------------------------------------------------------------------------
module tb_sramlike_port_bridge;

    logic        clk;
    logic        rst;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        stall;
    logic        hold;
    logic        flush;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    int errors = 0;
    int checks = 0;

    sramlike_port_bridge #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .stall      (stall),
        .hold       (hold),
        .flush      (flush),
        .req        (req),
        .wr         (wr),
        .size       (size),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .addr_ok    (addr_ok),
        .data_ok    (data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the stimulus is fixed-length, this only catches a hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle before sampling
    task automatic probe();
        #3;
    endtask

    initial begin
        rst        = 1'b1;
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        hold       = 1'b0;
        flush      = 1'b0;
        rdata      = 32'h0;
        addr_ok    = 1'b0;
        data_ok    = 1'b0;

        // ---------------- reset ----------------
        cyc(); cyc();
        rst = 1'b0;
        probe();
        check("rst_req",   req,        0);
        check("rst_stall", stall,      0);
        check("rst_rdata", sram_rdata, 0);
        $display("txn reset");

        // ---------------- read with WAIT ----------------
        cyc();
        sram_en = 1'b1; sram_wen = 4'b0000; sram_addr = 32'h1FC0_0006;
        addr_ok = 1'b1;
        probe();
        check("rd_c0_req",   req,   1);
        check("rd_c0_addr",  addr,  32'h1FC0_0004);
        check("rd_c0_size",  size,  2);
        check("rd_c0_wr",    wr,    0);
        check("rd_c0_stall", stall, 1);
        cyc();
        addr_ok = 1'b0;
        probe();
        check("rd_c1_req",   req,   0);
        check("rd_c1_stall", stall, 1);
        cyc();
        data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
        probe();
        check("rd_c2_req",   req,   0);
        check("rd_c2_stall", stall, 1);
        check("rd_c2_rdata", sram_rdata, 0);
        cyc();
        data_ok = 1'b0; rdata = 32'h0;
        probe();
        check("rd_c3_stall", stall, 0);
        check("rd_c3_req",   req,   0);
        check("rd_c3_rdata", sram_rdata, 32'hDEAD_BEEF);
        cyc();
        sram_en = 1'b0;
        probe();
        check("rd_c4_stall", stall, 0);
        check("rd_c4_rdata", sram_rdata, 32'hDEAD_BEEF);
        $display("txn read 0x1FC00006 -> 0xDEADBEEF");

        // ---------------- write size / addr decode (no addr_ok) ----------------
        sram_en = 1'b1; sram_addr = 32'h8000_0012; sram_wdata = 32'h0102_0304;
        sram_wen = 4'b0100;
        probe();
        check("wb_wr",    wr,    1);
        check("wb_size",  size,  0);
        check("wb_addr",  addr,  32'h8000_0012);
        check("wb_wdata", wdata, 32'h0102_0304);
        check("wb_req",   req,   1);
        sram_wen = 4'b1100; probe();
        check("wh_size", size, 1);
        sram_wen = 4'b1111; probe();
        check("ww_size", size, 2);
        sram_wen = 4'b0110; probe();
        check("wbad0110_size", size, 2);
        sram_wen = 4'b0101; probe();
        check("wbad0101_size", size, 2);
        sram_wen = 4'b0001; probe();
        check("wb0_size", size, 0);
        sram_wen = 4'b0011; probe();
        check("wh0_size", size, 1);
        sram_wen = 4'b0000; sram_addr = 32'h8000_0013; probe();
        check("rd_addr_mask", addr, 32'h8000_0010);
        check("rd_size",      size, 2);
        // flush in IDLE suppresses the request
        flush = 1'b1; probe();
        check("idle_flush_req",   req,   0);
        check("idle_flush_stall", stall, 0);
        flush = 1'b0;
        $display("txn write size decode");

        // ---------------- same-cycle completion + hold ----------------
        cyc();
        sram_en = 1'b1; sram_wen = 4'b0000; sram_addr = 32'h0000_0100;
        addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'hCAFE_F00D;
        probe();
        check("sc_req",   req,   1);
        check("sc_stall", stall, 1);
        cyc();
        addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0; hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            // a stray data_ok while in DONE must be ignored
            data_ok = (i == 2);
            rdata   = (i == 2) ? 32'h1111_1111 : 32'h0;
            probe();
            check($sformatf("hold%0d_stall", i), stall, 0);
            check($sformatf("hold%0d_req", i),   req,   0);
            check($sformatf("hold%0d_rdata", i), sram_rdata, 32'hCAFE_F00D);
            cyc();
        end
        data_ok = 1'b0; rdata = 32'h0; hold = 1'b0;
        probe();
        check("rel_stall", stall, 0);
        check("rel_req",   req,   0);
        check("rel_rdata", sram_rdata, 32'hCAFE_F00D);
        cyc();
        // back in IDLE: sram_en still high would request again
        probe();
        check("idle_again_req", req, 1);
        sram_en = 1'b0;
        probe();
        check("idle_again_stall", stall, 0);
        $display("txn same-cycle read 0x100 -> 0xCAFEF00D with hold");

        // ---------------- flush in WAIT, drain ----------------
        cyc();
        sram_en = 1'b1; sram_addr = 32'h0000_0200; addr_ok = 1'b1;
        probe();
        check("fl_c0_req", req, 1);
        cyc();
        addr_ok = 1'b0; flush = 1'b1;
        probe();
        check("fl_c1_req",   req,   0);
        check("fl_c1_stall", stall, 0);
        cyc();
        flush = 1'b0; sram_addr = 32'h0000_0300;
        for (int i = 0; i < 3; i++) begin
            data_ok = (i == 2);
            rdata   = (i == 2) ? 32'h1234_5678 : 32'h0;
            probe();
            check($sformatf("drain%0d_req", i),   req,   0);
            check($sformatf("drain%0d_stall", i), stall, 1);
            check($sformatf("drain%0d_rdata", i), sram_rdata, 32'hCAFE_F00D);
            cyc();
        end
        data_ok = 1'b0; rdata = 32'h0;
        probe();
        check("post_drain_req",   req,   1);
        check("post_drain_addr",  addr,  32'h0000_0300);
        check("post_drain_rdata", sram_rdata, 32'hCAFE_F00D);
        addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h0BAD_F00D;
        cyc();
        addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
        probe();
        check("new_done_stall", stall, 0);
        check("new_done_rdata", sram_rdata, 32'h0BAD_F00D);
        cyc();
        sram_en = 1'b0;
        $display("txn flushed read 0x200, drained, read 0x300 -> 0x0BADF00D");

        // ---------------- flush with data_ok in WAIT discards data ----------------
        sram_en = 1'b1; sram_addr = 32'h0000_0400; addr_ok = 1'b1;
        cyc();
        addr_ok = 1'b0; flush = 1'b1; data_ok = 1'b1; rdata = 32'h7777_7777;
        probe();
        check("fldo_stall", stall, 0);
        cyc();
        flush = 1'b0; data_ok = 1'b0; rdata = 32'h0; sram_en = 1'b0;
        probe();
        check("fldo_rdata", sram_rdata, 32'h0BAD_F00D);
        sram_en = 1'b1;
        probe();
        check("fldo_idle_req", req, 1);
        $display("txn flushed read 0x400 with same-cycle data_ok");

        // ---------------- reset while in WAIT ----------------
        addr_ok = 1'b1;
        cyc();
        addr_ok = 1'b0;
        probe();
        check("rw_wait_stall", stall, 1);
        check("rw_wait_req",   req,   0);
        rst = 1'b1; sram_en = 1'b0;
        cyc();
        rst = 1'b0; data_ok = 1'b1; rdata = 32'h5555_5555;
        probe();
        check("rw_req",   req,   0);
        check("rw_stall", stall, 0);
        check("rw_rdata", sram_rdata, 0);
        cyc();
        data_ok = 1'b0; rdata = 32'h0;
        probe();
        check("rw_stray_rdata", sram_rdata, 0);
        check("rw_stray_stall", stall, 0);
        sram_en = 1'b1;
        probe();
        check("rw_idle_req",   req,   1);
        check("rw_idle_stall", stall, 1);
        $display("txn reset during WAIT");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
